// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Shared opcodes, FSM state type and datapath width for the shared-ALU block.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu4_comb.sv
`default_nettype none
// ============================================================================
// Module  : alu4_comb
// Purely combinational 4-bit ALU; carry/overflow only for add and sub.
// Revision: 1.0
// ============================================================================
module alu4_comb
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op,
  output logic [ALU_W-1:0] res,
  output logic             car,
  output logic             of
);

  localparam logic [ALU_W:0] ONE = {{ALU_W{1'b0}}, 1'b1};

  logic [ALU_W:0] sum;
  logic [ALU_W:0] diff;

  // Subtraction as a + ~b + 1 so carry means "no borrow".
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + ONE;

  always_comb begin
    res = '0;
    car = 1'b0;
    of  = 1'b0;
    case (op)
      OP_ADD: begin
        res = sum[ALU_W-1:0];
        car = sum[ALU_W];
        of  = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        res = diff[ALU_W-1:0];
        car = diff[ALU_W];
        of  = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
      end
      OP_NOT: res = ~a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SLT: res = ($signed(a) < $signed(b)) ? ONE[ALU_W-1:0] : '0;
      OP_EQ:  res = (a == b) ? ONE[ALU_W-1:0] : '0;
      default: res = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_ctrl
// Arbitrates two valid/ready requesters onto one ALU, one operation in flight.
// Revision: 1.0
// ============================================================================
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [ALU_W-1:0] req_a0,
  input  logic [ALU_W-1:0] req_b0,
  input  logic [ALU_W-1:0] req_a1,
  input  logic [ALU_W-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_res,
  output logic             rsp_car,
  output logic             rsp_of,
  output logic [7:0]       op_count
);

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_res_q, rsp_res_d;
  logic             rsp_car_q, rsp_car_d;
  logic             rsp_of_q, rsp_of_d;
  logic [7:0]       op_count_q, op_count_d;

  logic             grant_id;
  logic             handshake;
  logic [ALU_W-1:0] alu_res;
  logic             alu_car;
  logic             alu_of;

  // Ties go to whoever was not served last, unless fixed priority is chosen.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = (ROUND_ROBIN != 0) ? ~last_id_q : 1'b0;
      default: grant_id = 1'b0;
    endcase
  end

  assign req_ready = ((state_q == IDLE) && !rst && (|req_valid)) ?
                     (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign handshake = |(req_valid & req_ready);

  alu4_comb u_alu (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .res (alu_res),
    .car (alu_car),
    .of  (alu_of)
  );

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_car_d   = rsp_car_q;
    rsp_of_d    = rsp_of_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = EXEC;
          a_d       = grant_id ? req_a1  : req_a0;
          b_d       = grant_id ? req_b1  : req_b0;
          op_d      = grant_id ? req_op1 : req_op0;
          id_d      = grant_id;
          last_id_d = grant_id;
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_res_d   = alu_res;
        rsp_car_d   = alu_car;
        rsp_of_d    = alu_of;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_id_q   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_car_q   <= 1'b0;
      rsp_of_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_car_q   <= rsp_car_d;
      rsp_of_q    <= rsp_of_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_car   = rsp_car_q;
  assign rsp_of    = rsp_of_q;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// Bench for alu_share_ctrl: a round-robin and a fixed-priority instance, both
// compared every cycle against a transaction-level reference model.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] rv[2];
  logic [3:0] a0[2], b0[2], a1[2], b1[2];
  logic [2:0] op0[2], op1[2];
  logic       rsp_rdy[2];
  logic [1:0] rdy[2];
  logic       vld[2], rid[2], car[2], ovf[2];
  logic [3:0] res[2];
  logic [7:0] cnt[2];

  alu_share_ctrl #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_a0(a0[0]), .req_b0(b0[0]), .req_a1(a1[0]), .req_b1(b1[0]),
    .req_op0(op0[0]), .req_op1(op1[0]), .rsp_valid(vld[0]), .rsp_ready(rsp_rdy[0]),
    .rsp_id(rid[0]), .rsp_res(res[0]), .rsp_car(car[0]), .rsp_of(ovf[0]),
    .op_count(cnt[0])
  );

  alu_share_ctrl #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_a0(a0[1]), .req_b0(b0[1]), .req_a1(a1[1]), .req_b1(b1[1]),
    .req_op0(op0[1]), .req_op1(op1[1]), .rsp_valid(vld[1]), .rsp_ready(rsp_rdy[1]),
    .rsp_id(rid[1]), .rsp_res(res[1]), .rsp_car(car[1]), .rsp_of(ovf[1]),
    .op_count(cnt[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one outstanding transaction, its age in cycles, and the
  // values the response port must currently show.
  int m_busy[2], m_age[2], m_last[2], m_cnt[2];
  int m_res[2], m_car[2], m_of[2], m_id[2];
  int inf_res[2], inf_car[2], inf_of[2], inf_id[2];
  int acc[2], acc_id[2];
  int ord0[$], ord1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void alu_ref(input int a, input int b, input int op,
                                  output int r, output int c, output int o);
    int sa, sb;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r = 0; c = 0; o = 0;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b) / 16; o = int'((sa + sb) > 7 || (sa + sb) < -8); end
      1: begin r = (a - b + 16) % 16; c = int'(a >= b); o = int'((sa - sb) > 7 || (sa - sb) < -8); end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = int'(sa < sb);
      default: r = int'(a == b);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_age[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
      m_res[k] = 0; m_car[k] = 0; m_of[k] = 0; m_id[k] = 0;
    end
  endtask

  initial begin : compare
    int g, er, r, c, o;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        g = 0; er = 0;
        if (!rst && m_busy[k] == 0 && rv[k] != 2'b00) begin
          if (rv[k] == 2'b01) g = 0;
          else if (rv[k] == 2'b10) g = 1;
          else g = (k == 0) ? 1 - m_last[k] : 0;
          er = 1 << g;
        end
        chk($sformatf("req_ready[%0d]", k), int'(rdy[k]), er);
        chk($sformatf("rsp_valid[%0d]", k), int'(vld[k]), int'(m_busy[k] == 1 && m_age[k] == 1));
        chk($sformatf("rsp_id[%0d]", k), int'(rid[k]), m_id[k]);
        chk($sformatf("rsp_res[%0d]", k), int'(res[k]), m_res[k]);
        chk($sformatf("rsp_car[%0d]", k), int'(car[k]), m_car[k]);
        chk($sformatf("rsp_of[%0d]", k), int'(ovf[k]), m_of[k]);
        chk($sformatf("op_count[%0d]", k), int'(cnt[k]), m_cnt[k]);
        acc[k] = int'((rv[k] & rdy[k]) != 2'b00);
        acc_id[k] = int'(rdy[k][1]);
        if (acc[k] != 0) begin
          if (k == 0) ord0.push_back(acc_id[k]);
          else ord1.push_back(acc_id[k]);
        end
        // Advance the model to what the next rising edge produces.
        if (rst) begin
          m_busy[k] = 0; m_age[k] = 0; m_last[k] = 1; m_cnt[k] = 0;
          m_res[k] = 0; m_car[k] = 0; m_of[k] = 0; m_id[k] = 0;
        end else if (m_busy[k] == 0) begin
          if (er != 0) begin
            if (g == 0) alu_ref(int'(a0[k]), int'(b0[k]), int'(op0[k]), r, c, o);
            else alu_ref(int'(a1[k]), int'(b1[k]), int'(op1[k]), r, c, o);
            m_busy[k] = 1; m_age[k] = 0; m_last[k] = g;
            inf_res[k] = r; inf_car[k] = c; inf_of[k] = o; inf_id[k] = g;
          end
        end else if (m_age[k] == 0) begin
          m_age[k] = 1;
          m_res[k] = inf_res[k]; m_car[k] = inf_car[k];
          m_of[k] = inf_of[k]; m_id[k] = inf_id[k];
        end else if (rsp_rdy[k]) begin
          m_cnt[k] = (m_cnt[k] + 1) % 256;
          m_busy[k] = 0;
        end
      end
    end
  end

  task automatic new_ops(input int k, input int j);
    if (j == 0) begin
      a0[k] = 4'($urandom); b0[k] = 4'($urandom); op0[k] = 3'($urandom);
    end else begin
      a1[k] = 4'($urandom); b1[k] = 4'($urandom); op1[k] = 3'($urandom);
    end
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (rv[k][j] && !(acc[k] != 0 && acc_id[k] == j)) begin
          if (($urandom % 20) == 0) rv[k][j] = 1'b0;
        end else begin
          rv[k][j] = (($urandom % 10) < 6);
          new_ops(k, j);
        end
      end
      rsp_rdy[k] = (($urandom % 10) < 7);
    end
  endtask

  task automatic run_one(input int a, input int b, input int op,
                         output int r, output int c, output int o,
                         output int id, output int lat);
    int n;
    rv[0] = 2'b01; a0[0] = 4'(a); b0[0] = 4'(b); op0[0] = 3'(op); rsp_rdy[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (acc[0] == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", n, 0);
    rv[0] = 2'b00;
    lat = 1;
    while (!vld[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = int'(res[0]); c = int'(car[0]); o = int'(ovf[0]); id = int'(rid[0]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int r, c, o, id, lat, n, c0;
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b00; a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
      op0[k] = '0; op1[k] = '0; rsp_rdy[k] = 1'b1; acc[k] = 0; acc_id[k] = 0;
    end

    // Model pinned against hand-computed values.
    alu_ref(7, 1, 0, r, c, o);  chk("ref_add", r * 100 + c * 10 + o, 801);
    alu_ref(8, 1, 1, r, c, o);  chk("ref_sub", r * 100 + c * 10 + o, 711);
    alu_ref(15, 1, 6, r, c, o); chk("ref_slt", r * 100 + c * 10 + o, 100);

    repeat (3) @(negedge clk);
    rv[0] = 2'b11; rv[1] = 2'b11;
    #2;
    chk("reset_ready0", int'(rdy[0]), 0);
    chk("reset_ready1", int'(rdy[1]), 0);
    chk("reset_count", int'(cnt[0]), 0);
    rv[0] = 2'b00; rv[1] = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    run_one(7, 1, 0, r, c, o, id, lat);
    chk("add_res", r, 8); chk("add_car", c, 0); chk("add_of", o, 1);
    chk("add_id", id, 0); chk("add_latency", lat, 2);
    @(negedge clk);
    chk("add_count", int'(cnt[0]), 1);

    run_one(0, 1, 1, r, c, o, id, lat);
    chk("sub0_res", r, 15); chk("sub0_car", c, 0); chk("sub0_of", o, 0);
    @(negedge clk);
    run_one(8, 1, 1, r, c, o, id, lat);
    chk("sub8_res", r, 7); chk("sub8_car", c, 1); chk("sub8_of", o, 1);
    @(negedge clk);
    run_one(15, 1, 6, r, c, o, id, lat);
    chk("slt_res", r, 1); chk("slt_flags", c + o, 0);
    @(negedge clk);
    run_one(5, 5, 7, r, c, o, id, lat);
    chk("eq_true", r, 1); chk("eq_flags", c + o, 0);
    @(negedge clk);
    run_one(5, 6, 7, r, c, o, id, lat);
    chk("eq_false", r, 0); chk("eq_false_flags", c + o, 0);
    @(negedge clk);

    // Contention: both requesters valid continuously on both instances.
    ord0.delete(); ord1.delete();
    for (int k = 0; k < 2; k++) begin
      rv[k] = 2'b11; rsp_rdy[k] = 1'b1; new_ops(k, 0); new_ops(k, 1);
    end
    repeat (30) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (acc[k] != 0) new_ops(k, acc_id[k]);
    end
    rv[0] = 2'b00; rv[1] = 2'b00;
    repeat (4) @(negedge clk);
    chk("rr_grants", ord0.size() >= 8 ? 1 : 0, 1);
    chk("fp_grants", ord1.size() >= 8 ? 1 : 0, 1);
    for (int i = 0; i < 8 && i < ord0.size(); i++)
      chk($sformatf("rr_order%0d", i), ord0[i], (i % 2 == 0) ? 1 : 0);
    for (int i = 0; i < 8 && i < ord1.size(); i++)
      chk($sformatf("fp_order%0d", i), ord1[i], 0);

    // Back-pressure on the round-robin instance.
    rsp_rdy[0] = 1'b0; rv[0] = 2'b01; a0[0] = 4'd3; b0[0] = 4'd4; op0[0] = 3'd0;
    n = 0;
    @(negedge clk);
    while (acc[0] == 0 && n < 20) begin @(negedge clk); n++; end
    rv[0] = 2'b11;
    while (!vld[0] && n < 40) begin @(negedge clk); n++; end
    chk("bp_reached", int'(vld[0]), 1);
    c0 = int'(cnt[0]);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(vld[0]), 1);
      chk("bp_res", int'(res[0]), 7);
      chk("bp_ready", int'(rdy[0]), 0);
      chk("bp_count", int'(cnt[0]), c0);
    end
    rsp_rdy[0] = 1'b1; rv[0] = 2'b00;
    @(negedge clk);
    chk("bp_release", int'(cnt[0]), (c0 + 1) % 256);

    // Randomized traffic; op_count wraps over this stretch.
    repeat (3000) begin
      @(negedge clk);
      drive_random();
    end
    rv[0] = 2'b00; rv[1] = 2'b00; rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    repeat (5) @(negedge clk);

    // Reset while an operation is in EXEC.
    rv[0] = 2'b10; a1[0] = 4'd2; b1[0] = 4'd2; op1[0] = 3'd0;
    n = 0;
    @(negedge clk);
    while (acc[0] == 0 && n < 20) begin @(negedge clk); n++; end
    rv[0] = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", int'(vld[0]), 0);
    chk("rst_count", int'(cnt[0]), 0);
    rst = 1'b0;
    ord0.delete(); ord1.delete();
    rv[0] = 2'b11; rv[1] = 2'b11;
    repeat (2) @(negedge clk);
    rv[0] = 2'b00; rv[1] = 2'b00;
    chk("rst_tie_rr", ord0.size() > 0 ? ord0[0] : 9, 0);
    chk("rst_tie_fp", ord1.size() > 0 ? ord1[0] : 9, 0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbiter and sequencer that shares one 4-bit ALU between two requesters. It uses a valid/ready handshake per requester and round-robin grant, and keeps one operation in flight at a time. Operands are registered, the combinational ALU is evaluated, and the result and flags are captured and held until the consumer accepts them. It sits between the lab's input-side logic (switch/key decoders) and the result display path.

## Interface
- `ROUND_ROBIN`, default 1: 1 selects round-robin; 0 gives requester 0 fixed priority.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester request valid (bit i = requester i).
- `req_ready` out 2: per-requester accept; one-hot or zero.
- `req_a0`, `req_b0` in 4 each: operands from requester 0.
- `req_a1`, `req_b1` in 4 each: operands from requester 1.
- `req_op0`, `req_op1` in 3 each: opcodes.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_res` out 4: result.
- `rsp_car` out 1: carry flag.
- `rsp_of` out 1: overflow flag.
- `op_count` out 8: number of completed responses, wraps modulo 256.

## Operation
- Opcodes:
  - 000 add: {car,res}=a+b; of=(a3==b3)&&(res3!=a3).
  - 001 sub: {car,res}=a+(~b)+1; of=(a3!=b3)&&(res3!=a3).
  - 010 not: res=~a.
  - 011 and, 100 or, 101 xor.
  - 110 signed less-than: res=4'b0001 if $signed(a)<$signed(b), else 0.
  - 111 equal: res=4'b0001 if a==b, else 0.
  - car and of are 0 for every opcode other than 000 and 001.
- States:
  - IDLE: wait for a request.
  - EXEC: ALU is evaluating.
  - RESP: result held for the consumer.
- Transitions:
  - IDLE -> EXEC on handshake (req_valid[i] && req_ready[i]).
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready.
- Grant is combinational in IDLE only:
  - One valid requester: that requester wins.
  - Both valid, ROUND_ROBIN=1: the requester other than `last_id` wins.
  - Both valid, ROUND_ROBIN=0: requester 0 wins.
- req_ready[i] = (state==IDLE) && grant==i. It is 0 in EXEC and RESP.
- On handshake: latch a, b, op and id into operand registers; `last_id` <= id.
- In EXEC: ALU outputs are captured into rsp_res, rsp_car and rsp_of.
- In RESP: rsp_valid=1 and the rsp_* outputs stay stable until rsp_ready.
- op_count increments on the cycle rsp_valid && rsp_ready.
- Reset values:
  - state=IDLE, last_id=1 (so requester 0 wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_res=0, rsp_car=0, rsp_of=0, op_count=0.
  - req_ready=0 while rst=1.

## Timing
- Handshake at edge N → EXEC during cycle N+1 → rsp_valid visible after edge N+2.
- Best-case spacing is one accepted request every 3 cycles. The next acceptance can occur at the edge after the rsp_ready handshake.
- A requester must hold valid and its operands stable until ready. Operands that change while ready=0 are don't-care.
- A request is never lost: valid without ready simply waits.
- rsp_ready=0 in RESP stalls indefinitely. Both req_ready bits stay 0 for the whole stall.
- Deasserting req_valid before ready is allowed; no transfer occurs.
- rst asserted in EXEC or RESP: the in-flight operation is discarded, with no response and no op_count increment. All registers return to reset values on that edge.
- op_count wraps from 255 to 0.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams OP_ADD..OP_EQ (3-bit).
  - State enum IDLE/EXEC/RESP.
  - Width constant ALU_W=4.
- One sub-module, `alu4_comb`: purely combinational ALU implementing the opcode table above. It has no latches, and every output is assigned for every opcode. It is instantiated once.
- Top level holds the arbiter, FSM, operand registers, result registers and counter.

## Test plan
- Single request: req0 add a=7, b=1; rsp_ready=1. Expect rsp_res=8, car=0, of=1, rsp_id=0. rsp_valid rises 2 cycles after the handshake; op_count=1.
- Sub corner: a=0, b=1, op=001. Expect res=4'hF, car=0, of=0. Then a=8, b=1. Expect res=7, car=1, of=1.
- Contention: both valid continuously, 4 ops each.
  - ROUND_ROBIN=1: grant order 0,1,0,1…
  - ROUND_ROBIN=0: requester 0 wins every tie.
  - Results always match each requester's operands.
- Back-pressure: hold rsp_ready=0 for 10 cycles in RESP. Expect outputs stable, req_ready=0 throughout, and op_count unchanged until release.
- Compare ops: a=4'hF (-1), b=1 with op 110 gives res=1; a=5, b=5 with op 111 gives res=1; a=5, b=6 with op 111 gives res=0. car=of=0 in all three.
- Reset mid-operation: assert rst in EXEC. Next cycle: state IDLE, rsp_valid=0, op_count unchanged at its reset value 0, and the first tie after reset goes to requester 0.
